ptw_arbiter: RTL and testbench

// - Shares one page-table walker (PTW) between the instruction-side and data-side TLBs.
// - Sits between the two TLB miss ports and the PTW. It feeds the resp bundles
//   (valid / error / ppn) that the TLB blocks consume on their io_*_ptw_resp_* inputs.
// - One walk is outstanding at a time. Grants are round-robin.
// - Each response is routed back to the requester that issued the walk.
// - A hung walk is ended with an error response after TIMEOUT cycles.

---
 rtl/ptw_arbiter.sv | 120 ++++++++++++
 tb/tb_ptw_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ptw_arbiter.sv
// Round-robin arbiter sharing one page-table walker between the imem and dmem TLBs.
// One walk is outstanding at a time. A hung walk ends with an error response after TIMEOUT WAIT cycles.
//
// state  | meaning
// IDLE   | waiting for a TLB miss; grant and latch the owner's VPN
// REQ    | presenting the latched VPN to the PTW until it is accepted
// WAIT   | walk in flight; count cycles until a response or a timeout
// RESP   | one-cycle response pulse to the owner
module ptw_arbiter #(
  parameter int VPN_W   = 20,
  parameter int PPN_W   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             io_imem_req_valid,
  output logic             io_imem_req_ready,
  input  logic [VPN_W-1:0] io_imem_req_bits_vpn,
  output logic             io_imem_resp_valid,
  output logic             io_imem_resp_bits_error,
  output logic [PPN_W-1:0] io_imem_resp_bits_ppn,
  input  logic             io_dmem_req_valid,
  output logic             io_dmem_req_ready,
  input  logic [VPN_W-1:0] io_dmem_req_bits_vpn,
  output logic             io_dmem_resp_valid,
  output logic             io_dmem_resp_bits_error,
  output logic [PPN_W-1:0] io_dmem_resp_bits_ppn,
  output logic             io_ptw_req_valid,
  input  logic             io_ptw_req_ready,
  output logic [VPN_W-1:0] io_ptw_req_bits_vpn,
  input  logic             io_ptw_resp_valid,
  input  logic             io_ptw_resp_bits_error,
  input  logic [PPN_W-1:0] io_ptw_resp_bits_ppn,
  output logic             io_busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam int               CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [1:0]       state;
  logic             rr_ptr;   // 0: imem has priority, 1: dmem has priority
  logic             owner;    // 0: imem, 1: dmem
  logic [VPN_W-1:0] vpn_q;
  logic             err_q;
  logic [PPN_W-1:0] ppn_q;
  logic [CNT_W-1:0] cnt;

  logic gnt_imem;
  logic gnt_dmem;
  logic timeout_hit;

  assign gnt_imem = (state == S_IDLE) && io_imem_req_valid && (!io_dmem_req_valid || !rr_ptr);
  assign gnt_dmem = (state == S_IDLE) && io_dmem_req_valid && (!io_imem_req_valid || rr_ptr);
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      rr_ptr <= 1'b0;
      owner  <= 1'b0;
      vpn_q  <= '0;
      err_q  <= 1'b0;
      ppn_q  <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_imem || gnt_dmem) begin
            owner  <= gnt_dmem;
            vpn_q  <= gnt_dmem ? io_dmem_req_bits_vpn : io_imem_req_bits_vpn;
            rr_ptr <= !gnt_dmem;
            state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (io_ptw_req_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          // A real response takes precedence over a coincident timeout.
          if (io_ptw_resp_valid) begin
            err_q <= io_ptw_resp_bits_error;
            ppn_q <= io_ptw_resp_bits_ppn;
            state <= S_RESP;
          end else if (timeout_hit) begin
            err_q <= 1'b1;
            ppn_q <= '0;
            state <= S_RESP;
          end
        end
        S_RESP: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign io_imem_req_ready = gnt_imem;
  assign io_dmem_req_ready = gnt_dmem;

  assign io_ptw_req_valid    = (state == S_REQ);
  assign io_ptw_req_bits_vpn = vpn_q;

  assign io_imem_resp_valid      = (state == S_RESP) && !owner;
  assign io_dmem_resp_valid      = (state == S_RESP) && owner;
  assign io_imem_resp_bits_error = io_imem_resp_valid && err_q;
  assign io_dmem_resp_bits_error = io_dmem_resp_valid && err_q;
  assign io_imem_resp_bits_ppn   = io_imem_resp_valid ? ppn_q : '0;
  assign io_dmem_resp_bits_ppn   = io_dmem_resp_valid ? ppn_q : '0;

  assign io_busy = (state != S_IDLE);

endmodule

// File: tb/tb_ptw_arbiter.sv
// Scoreboard bench for ptw_arbiter: stimulus pushes expected grants/responses, a negedge monitor checks them.
module tb_ptw_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_valid, imem_ready, imem_rv, imem_err;
  logic [19:0] imem_vpn;
  logic [31:0] imem_ppn;
  logic        dmem_valid, dmem_ready, dmem_rv, dmem_err;
  logic [19:0] dmem_vpn;
  logic [31:0] dmem_ppn;
  logic        ptw_valid, ptw_ready, ptw_rv, ptw_rerr, busy;
  logic [19:0] ptw_vpn;
  logic [31:0] ptw_rppn;

  ptw_arbiter #(.VPN_W(20), .PPN_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .io_imem_req_valid(imem_valid), .io_imem_req_ready(imem_ready),
    .io_imem_req_bits_vpn(imem_vpn), .io_imem_resp_valid(imem_rv),
    .io_imem_resp_bits_error(imem_err), .io_imem_resp_bits_ppn(imem_ppn),
    .io_dmem_req_valid(dmem_valid), .io_dmem_req_ready(dmem_ready),
    .io_dmem_req_bits_vpn(dmem_vpn), .io_dmem_resp_valid(dmem_rv),
    .io_dmem_resp_bits_error(dmem_err), .io_dmem_resp_bits_ppn(dmem_ppn),
    .io_ptw_req_valid(ptw_valid), .io_ptw_req_ready(ptw_ready),
    .io_ptw_req_bits_vpn(ptw_vpn), .io_ptw_resp_valid(ptw_rv),
    .io_ptw_resp_bits_error(ptw_rerr), .io_ptw_resp_bits_ppn(ptw_rppn),
    .io_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        own;
    logic        err;
    logic [31:0] ppn;
    logic [31:0] cyc;
  } exp_t;

  exp_t rq[$];
  logic gq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fail_now(string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: expected event did not occur (cycle %0d)", name, cyc);
  endfunction

  // Monitor: grants and responses are matched against the queues in issue order.
  always @(negedge clk) begin
    if (reset_n) begin
      if (imem_ready || dmem_ready) begin
        if (gq.size() == 0) chk("grant_expected", {62'd0, imem_ready, dmem_ready}, 64'd0);
        else begin
          logic g;
          g = gq.pop_front();
          chk("grant_owner", {63'd0, dmem_ready}, {63'd0, g});
          chk("grant_onehot", {63'd0, imem_ready & dmem_ready}, 64'd0);
        end
      end
      if (imem_rv || dmem_rv) begin
        if (rq.size() == 0) chk("resp_expected", {62'd0, imem_rv, dmem_rv}, 64'd0);
        else begin
          exp_t e;
          e = rq.pop_front();
          chk("resp_owner", {62'd0, imem_rv, dmem_rv}, e.own ? 64'd1 : 64'd2);
          chk("resp_err", {63'd0, e.own ? dmem_err : imem_err}, {63'd0, e.err});
          chk("resp_ppn", {32'd0, e.own ? dmem_ppn : imem_ppn}, {32'd0, e.ppn});
          chk("resp_cycle", 64'(cyc), {32'd0, e.cyc});
        end
      end
      if (!imem_rv) chk("imem_bits_zero", {31'd0, imem_err, imem_ppn}, 64'd0);
      if (!dmem_rv) chk("dmem_bits_zero", {31'd0, dmem_err, dmem_ppn}, 64'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge clk);
      if (imem_ready || dmem_ready) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    imem_valid = 0; dmem_valid = 0; ptw_ready = 0; ptw_rv = 0;
    reset_n = 0;
    @(negedge clk);
    chk("rst_ctrl", {56'd0, imem_ready, imem_rv, imem_err, dmem_ready, dmem_rv, dmem_err, ptw_valid, busy}, 64'd0);
    chk("rst_ppn", {imem_ppn, dmem_ppn}, 64'd0);
    chk("rst_vpn", {44'd0, ptw_vpn}, 64'd0);
    step();
    reset_n = 1;
  endtask

  // sdly < 0: PTW never answers and the timeout must fire.
  task automatic walk(input logic own, input logic [19:0] vpn, input int rdly, input int sdly,
                      input logic perr, input logic [31:0] pppn,
                      input logic eerr, input logic [31:0] eppn, input logic drop);
    bit   ok;
    int   lat;
    exp_t e;
    wait_grant(ok);
    if (!ok) begin
      fail_now("grant_timeout");
      return;
    end
    lat = (sdly < 0) ? rdly + 6 : rdly + 3 + sdly;
    e.own = own; e.err = eerr; e.ppn = eppn; e.cyc = 32'(cyc + lat);
    rq.push_back(e);
    step();
    if (drop) begin imem_valid = 0; dmem_valid = 0; end
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk);
      chk("req_valid_hold", {63'd0, ptw_valid}, 64'd1);
      chk("req_vpn_hold", {44'd0, ptw_vpn}, {44'd0, vpn});
      step();
    end
    ptw_ready = 1;
    @(negedge clk);
    chk("req_valid", {63'd0, ptw_valid}, 64'd1);
    chk("req_vpn", {44'd0, ptw_vpn}, {44'd0, vpn});
    step();
    ptw_ready = 0;
    if (sdly >= 0) begin
      repeat (sdly) step();
      ptw_rv = 1; ptw_rerr = perr; ptw_rppn = pppn;
      step();
      ptw_rv = 0; ptw_rerr = 0; ptw_rppn = 0;
    end
    for (int n = 0; n < 40 && rq.size() != 0; n++) @(posedge clk);
    #1;
    if (rq.size() != 0) begin
      fail_now("resp_timeout");
      rq.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    imem_vpn = 0; dmem_vpn = 0; ptw_rerr = 0; ptw_rppn = 0;
    step();
    do_reset();

    // Single imem walk at minimum latency.
    gq.push_back(1'b0);
    imem_valid = 1; imem_vpn = 20'h12345;
    walk(1'b0, 20'h12345, 0, 0, 1'b0, 32'hABCD0, 1'b0, 32'hABCD0, 1'b1);

    // Both requesting from reset: imem, dmem, imem.
    do_reset();
    gq.push_back(1'b0); gq.push_back(1'b1); gq.push_back(1'b0);
    imem_valid = 1; imem_vpn = 20'h11111;
    dmem_valid = 1; dmem_vpn = 20'h22222;
    walk(1'b0, 20'h11111, 0, 0, 1'b0, 32'h1000, 1'b0, 32'h1000, 1'b0);
    walk(1'b1, 20'h22222, 0, 0, 1'b0, 32'h2000, 1'b0, 32'h2000, 1'b0);
    walk(1'b0, 20'h11111, 0, 0, 1'b0, 32'h3000, 1'b0, 32'h3000, 1'b1);

    // PTW back-pressure for 5 cycles.
    gq.push_back(1'b1);
    dmem_valid = 1; dmem_vpn = 20'h0F0F0;
    walk(1'b1, 20'h0F0F0, 5, 0, 1'b0, 32'h4444, 1'b0, 32'h4444, 1'b1);

    // No PTW answer: timeout error 4 cycles into WAIT.
    gq.push_back(1'b0);
    imem_valid = 1; imem_vpn = 20'h00ABC;
    walk(1'b0, 20'h00ABC, 0, -1, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);

    // Response coinciding with the last timeout cycle wins.
    gq.push_back(1'b1);
    dmem_valid = 1; dmem_vpn = 20'h54321;
    walk(1'b1, 20'h54321, 0, 3, 1'b0, 32'h0BEEF, 1'b0, 32'h0BEEF, 1'b1);

    // PTW fault passes through.
    gq.push_back(1'b0);
    imem_valid = 1; imem_vpn = 20'h00777;
    walk(1'b0, 20'h00777, 0, 1, 1'b1, 32'h777, 1'b1, 32'h777, 1'b1);

    // Stray PTW response in IDLE is ignored.
    ptw_rv = 1; ptw_rerr = 1; ptw_rppn = 32'hDEAD;
    @(negedge clk);
    chk("stray_busy0", {63'd0, busy}, 64'd0);
    step();
    ptw_rv = 0; ptw_rerr = 0; ptw_rppn = 0;
    @(negedge clk);
    chk("stray_busy1", {63'd0, busy}, 64'd0);
    chk("stray_reqv", {63'd0, ptw_valid}, 64'd0);
    step();

    // Reset during WAIT aborts the walk and restores imem priority.
    gq.push_back(1'b0);
    imem_valid = 1; imem_vpn = 20'h13579;
    wait_grant(ok);
    if (!ok) fail_now("rst_grant_timeout");
    step();
    imem_valid = 0; ptw_ready = 1;
    step();
    ptw_ready = 0;
    @(negedge clk);
    chk("wait_busy", {63'd0, busy}, 64'd1);
    step();
    reset_n = 0;
    @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_reqv", {63'd0, ptw_valid}, 64'd0);
    step();
    reset_n = 1;
    ptw_rv = 1; ptw_rppn = 32'h9999;
    step();
    ptw_rv = 0; ptw_rppn = 0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_busy", {63'd0, busy}, 64'd0);
      step();
    end
    gq.push_back(1'b0);
    imem_valid = 1; imem_vpn = 20'h2468A;
    dmem_valid = 1; dmem_vpn = 20'h3579B;
    walk(1'b0, 20'h2468A, 0, 0, 1'b0, 32'h5555, 1'b0, 32'h5555, 1'b1);

    repeat (3) step();
    chk("grants_consumed", 64'(gq.size()), 64'd0);
    chk("resps_consumed", 64'(rq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
